// File: rtl/mc_ctrl_pkg.sv
// Shared control encodings (the ctrl_encode_def set) for the multicycle
// controller: FSM states, ALU ops, instruction classes, mux selects and
// opcode/funct values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_RTYPE   = 4'd1,
    CL_ITYPE   = 4'd2,
    CL_LW      = 4'd3,
    CL_SW      = 4'd4,
    CL_BEQ     = 4'd5,
    CL_BNE     = 4'd6,
    CL_J       = 4'd7,
    CL_JAL     = 4'd8
  } instr_class_e;

  // Next-PC select
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // Destination register select
  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  // ALU operand selects
  localparam logic       ALUSRCA_PC   = 1'b0;
  localparam logic       ALUSRCA_RS   = 1'b1;
  localparam logic [1:0] ALUSRCB_RT   = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd2;

  // Immediate extension
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // R-type and branch instructions take their second operand from rt.
  function automatic logic class_uses_rt(instr_class_e c);
    return (c == CL_RTYPE) || (c == CL_BEQ) || (c == CL_BNE);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. master = datapath side (drives the
// instruction fields and Zero), slave = controller side.
interface mc_ctrl_if;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       RFWrite;
  logic       DMWrite;
  logic [3:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       EXTOp;
  logic [1:0] NPCOp;
  logic [1:0] WDSel;
  logic [1:0] GPRSel;
  logic       illegal;
  logic [2:0] state;

  modport master (
    output Op, Funct, Zero,
    input  PCWrite, IRWrite, RFWrite, DMWrite, ALUOp, ALUSrcA, ALUSrcB,
           EXTOp, NPCOp, WDSel, GPRSel, illegal, state
  );

  modport slave (
    input  Op, Funct, Zero,
    output PCWrite, IRWrite, RFWrite, DMWrite, ALUOp, ALUSrcA, ALUSrcB,
           EXTOp, NPCOp, WDSel, GPRSel, illegal, state
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Funct -> instruction class, ALU op
// and immediate extension. jal is only recognised when MCCTRL_JAL_EN is
// defined; otherwise it falls through to the illegal class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   i_op,
  input  logic [5:0]   i_funct,
  output instr_class_e o_class,
  output alu_op_e      o_alu_op,
  output logic         o_ext_op
);

  // Classify the instruction and pick its ALU operation
  always_comb begin
    o_class  = CL_ILLEGAL;
    o_alu_op = ALU_ADD;
    o_ext_op = EXT_SIGN;
    case (i_op)
      OP_RTYPE: begin
        o_class = CL_RTYPE;
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_NOR:  o_alu_op = ALU_NOR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SLTU: o_alu_op = ALU_SLTU;
          default: o_class  = CL_ILLEGAL;
        endcase
      end
      OP_ADDI: begin o_class = CL_ITYPE; o_alu_op = ALU_ADD; o_ext_op = EXT_SIGN; end
      OP_SLTI: begin o_class = CL_ITYPE; o_alu_op = ALU_SLT; o_ext_op = EXT_SIGN; end
      OP_ANDI: begin o_class = CL_ITYPE; o_alu_op = ALU_AND; o_ext_op = EXT_ZERO; end
      OP_ORI:  begin o_class = CL_ITYPE; o_alu_op = ALU_OR;  o_ext_op = EXT_ZERO; end
      OP_LUI:  begin o_class = CL_ITYPE; o_alu_op = ALU_LUI; o_ext_op = EXT_ZERO; end
      OP_LW:   begin o_class = CL_LW;    o_alu_op = ALU_ADD; o_ext_op = EXT_SIGN; end
      OP_SW:   begin o_class = CL_SW;    o_alu_op = ALU_ADD; o_ext_op = EXT_SIGN; end
      OP_BEQ:  begin o_class = CL_BEQ;   o_alu_op = ALU_SUB; end
      OP_BNE:  begin o_class = CL_BNE;   o_alu_op = ALU_SUB; end
      OP_J:    o_class = CL_J;
`ifdef MCCTRL_JAL_EN
      OP_JAL:  o_class = CL_JAL;
`else
      OP_JAL:  o_class = CL_ILLEGAL;
`endif
      default: o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller FSM (IF/ID/EXE/MEM/WB) with combinational control
// outputs. Optional jal support via MCCTRL_JAL_EN (see mc_decode).
// While rst is high the state is IF and every write enable is held low.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input logic     clk,
  input logic     rst,
  mc_ctrl_if.slave bus
);

  state_e       r_state;
  state_e       w_next;
  instr_class_e w_class;
  alu_op_e      w_dec_alu;
  logic         w_dec_ext;

  logic         w_pc_write;
  logic         w_ir_write;
  logic         w_rf_write;
  logic         w_dm_write;
  logic         w_illegal;
  alu_op_e      w_alu_op;
  logic         w_srca;
  logic [1:0]   w_srcb;
  logic         w_ext;
  logic [1:0]   w_npc;
  logic [1:0]   w_wd;
  logic [1:0]   w_gpr;

  mc_decode u_decode (
    .i_op     (bus.Op),
    .i_funct  (bus.Funct),
    .o_class  (w_class),
    .o_alu_op (w_dec_alu),
    .o_ext_op (w_dec_ext)
  );

  // State register, forced to IF asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_next     = ST_IF;
    w_pc_write = 1'b0;
    w_ir_write = 1'b0;
    w_rf_write = 1'b0;
    w_dm_write = 1'b0;
    w_illegal  = 1'b0;
    w_alu_op   = ALU_ADD;
    w_srca     = ALUSRCA_PC;
    w_srcb     = ALUSRCB_FOUR;
    w_ext      = EXT_SIGN;
    w_npc      = NPC_PC4;
    w_wd       = WD_ALU;
    w_gpr      = GPR_RD;

    // ALU operands stay as set up in EXE through MEM and WB so the
    // result feeding memory / the register file does not move.
    if (r_state inside {ST_EXE, ST_MEM, ST_WB}) begin
      w_srca   = ALUSRCA_RS;
      w_srcb   = class_uses_rt(w_class) ? ALUSRCB_RT : ALUSRCB_IMM;
      w_alu_op = w_dec_alu;
      w_ext    = w_dec_ext;
    end

    case (r_state)
      ST_IF: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_next     = ST_ID;
      end
      ST_ID: begin
        case (w_class)
          CL_J: begin
            w_pc_write = 1'b1;
            w_npc      = NPC_JUMP;
            w_next     = ST_IF;
          end
          CL_JAL: begin
            w_pc_write = 1'b1;
            w_npc      = NPC_JUMP;
            w_rf_write = 1'b1;
            w_gpr      = GPR_RA;
            w_wd       = WD_PC4;
            w_next     = ST_IF;
          end
          CL_ILLEGAL: begin
            w_illegal = 1'b1;
            w_next    = ST_IF;
          end
          default: w_next = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (w_class)
          CL_RTYPE, CL_ITYPE: w_next = ST_WB;
          CL_LW, CL_SW:       w_next = ST_MEM;
          CL_BEQ: begin
            w_npc      = NPC_BRANCH;
            w_pc_write = bus.Zero;
            w_next     = ST_IF;
          end
          CL_BNE: begin
            w_npc      = NPC_BRANCH;
            w_pc_write = ~bus.Zero;
            w_next     = ST_IF;
          end
          default: w_next = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (w_class == CL_SW) begin
          w_dm_write = 1'b1;
        end
        w_next = (w_class == CL_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        w_rf_write = 1'b1;
        w_wd       = (w_class == CL_LW) ? WD_MEM : WD_ALU;
        w_gpr      = (w_class == CL_RTYPE) ? GPR_RD : GPR_RT;
        w_next     = ST_IF;
      end
      default: w_next = ST_IF;
    endcase

    if (rst) begin
      w_pc_write = 1'b0;
      w_ir_write = 1'b0;
      w_rf_write = 1'b0;
      w_dm_write = 1'b0;
      w_illegal  = 1'b0;
    end
  end

  assign bus.PCWrite = w_pc_write;
  assign bus.IRWrite = w_ir_write;
  assign bus.RFWrite = w_rf_write;
  assign bus.DMWrite = w_dm_write;
  assign bus.illegal = w_illegal;
  assign bus.ALUOp   = w_alu_op;
  assign bus.ALUSrcA = w_srca;
  assign bus.ALUSrcB = w_srcb;
  assign bus.EXTOp   = w_ext;
  assign bus.NPCOp   = w_npc;
  assign bus.WDSel   = w_wd;
  assign bus.GPRSel  = w_gpr;
  assign bus.state   = r_state;

endmodule
